// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM stage and data memory.
//   req   : access request, held until ready
//   we    : 1 = store, 0 = load
//   addr  : word-aligned byte address
//   wdata : store data, replicated across byte lanes
//   be    : byte enables (4'b1111 for loads)
//   ready : access completes in the cycle it is high
//   rdata : read word, valid while ready = 1
// master = MEM stage side, slave = memory side.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: consumes the EX/MEM bundle, performs loads/stores on a
// ready-handshaked data-memory port, formats load data, and registers MEM/WB.
// Stalls upstream while an access is outstanding; an FSM times out an access
// that never completes and raises a one-cycle registered fault.
// Ports:
//   clk, reset (active-low, synchronous)
//   ex_mem_*   : EX/MEM bundle in (pc, alu_result, rs2_data, rd_addr, funct3,
//                control_signals, valid)
//   dmem       : data-memory port (mem_stage_if.master)
//   mem_stall  : hold EX/MEM and earlier stages
//   mem_fault / mem_fault_cause : one-cycle fault pulse, 0 = misaligned, 1 = timeout
//   mem_wb_*   : MEM/WB register out
module mem_stage #(
    parameter int unsigned CTRL_W         = 16,
    parameter int unsigned CTRL_MEM_READ  = 0,
    parameter int unsigned CTRL_MEM_WRITE = 1,
    parameter int unsigned DMEM_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ex_mem_pc,
    input  logic [31:0]       ex_mem_alu_result,
    input  logic [31:0]       ex_mem_rs2_data,
    input  logic [4:0]        ex_mem_rd_addr,
    input  logic [2:0]        ex_mem_funct3,
    input  logic [CTRL_W-1:0] ex_mem_control_signals,
    input  logic              ex_mem_valid,
    mem_stage_if.master       dmem,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic              mem_fault_cause,
    output logic [31:0]       mem_wb_pc,
    output logic [31:0]       mem_wb_alu_result,
    output logic [31:0]       mem_wb_mem_data,
    output logic [4:0]        mem_wb_rd_addr,
    output logic [CTRL_W-1:0] mem_wb_control_signals,
    output logic              mem_wb_valid
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;
    localparam logic [7:0] TIMEOUT_CNT = 8'(DMEM_TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              fault_q, cause_q;
    logic [31:0]       wb_pc_q, wb_alu_q, wb_data_q;
    logic [4:0]        wb_rd_q;
    logic [CTRL_W-1:0] wb_ctrl_q;
    logic              wb_valid_q;

    logic        is_store, access, size_ok, addr_ok, misaligned, req, stall;
    logic        fault_evt, timeout_evt, wb_kill;
    logic [1:0]  off;
    logic [15:0] lane;
    logic [31:0] load_data;

    assign off = ex_mem_alu_result[1:0];

    // Access decode and alignment check
    always_comb begin
        is_store = ex_mem_control_signals[CTRL_MEM_WRITE];
        access   = ex_mem_valid & (ex_mem_control_signals[CTRL_MEM_READ] | is_store);
        case (ex_mem_funct3[1:0])
            2'b00:   addr_ok = 1'b1;
            2'b01:   addr_ok = ~off[0];
            2'b10:   addr_ok = (off == 2'b00);
            default: addr_ok = 1'b0;
        endcase
        // Unsigned variants (funct3[2]) exist only for byte/half loads
        size_ok    = ~ex_mem_funct3[2] | (~is_store & ~ex_mem_funct3[1]);
        misaligned = access & ~(size_ok & addr_ok);
        req        = reset & access & ~misaligned & (state_q != FAULT);
        stall      = req & ~dmem.ready;
    end

    // Memory port drive
    always_comb begin
        dmem.req  = req;
        dmem.we   = is_store;
        dmem.addr = {ex_mem_alu_result[31:2], 2'b00};
        case (ex_mem_funct3[1:0])
            2'b00: begin
                dmem.wdata = {4{ex_mem_rs2_data[7:0]}};
                dmem.be    = 4'b0001 << off;
            end
            2'b01: begin
                dmem.wdata = {2{ex_mem_rs2_data[15:0]}};
                dmem.be    = 4'b0011 << off;
            end
            default: begin
                dmem.wdata = ex_mem_rs2_data;
                dmem.be    = 4'b1111;
            end
        endcase
        if (!is_store) dmem.be = 4'b1111;
    end

    // Load formatting: shift the addressed lane down, then extend
    always_comb begin
        lane = 16'(dmem.rdata >> {off, 3'b000});
        case (ex_mem_funct3)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_data = dmem.rdata;
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = 32'd0;
        endcase
        if (!access || is_store || misaligned) load_data = 32'd0;
    end

    // Access FSM
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        fault_evt   = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                fault_evt = misaligned;
                if (req && !dmem.ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                // req drops only if upstream broke the hold contract; abandon then
                if (!req || dmem.ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d     = FAULT;
                    wait_cnt_d  = 8'd0;
                    timeout_evt = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wb_kill = misaligned | (state_q == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            fault_q    <= 1'b0;
            cause_q    <= 1'b0;
            wb_pc_q    <= 32'd0;
            wb_alu_q   <= 32'd0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_ctrl_q  <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_evt | timeout_evt;
            cause_q    <= timeout_evt;
            if (stall) begin
                wb_valid_q <= 1'b0;
                wb_ctrl_q  <= '0;
            end else begin
                wb_pc_q    <= ex_mem_pc;
                wb_alu_q   <= ex_mem_alu_result;
                wb_data_q  <= load_data;
                wb_rd_q    <= ex_mem_rd_addr;
                wb_valid_q <= ex_mem_valid & ~wb_kill;
                wb_ctrl_q  <= wb_kill ? '0 : ex_mem_control_signals;
            end
        end
    end

    assign mem_stall              = stall;
    assign mem_fault              = fault_q;
    assign mem_fault_cause        = cause_q;
    assign mem_wb_pc              = wb_pc_q;
    assign mem_wb_alu_result      = wb_alu_q;
    assign mem_wb_mem_data        = wb_data_q;
    assign mem_wb_rd_addr         = wb_rd_q;
    assign mem_wb_control_signals = wb_ctrl_q;
    assign mem_wb_valid           = wb_valid_q;
endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized instructions,
// each checked against a behavioural model of the MEM-stage rules.
module tb_mem_stage;
    localparam int unsigned CW = 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc, alu, rs2;
    logic [4:0]    rd;
    logic [2:0]    f3;
    logic [CW-1:0] ctrl;
    logic          vld;
    logic          mem_stall, mem_fault, mem_fault_cause, mem_wb_valid;
    logic [31:0]   mem_wb_pc, mem_wb_alu_result, mem_wb_mem_data;
    logic [4:0]    mem_wb_rd_addr;
    logic [CW-1:0] mem_wb_control_signals;

    always #5 clk = ~clk;

    mem_stage_if dmem ();

    mem_stage #(
        .CTRL_W(CW), .CTRL_MEM_READ(0), .CTRL_MEM_WRITE(1), .DMEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_mem_pc(pc), .ex_mem_alu_result(alu), .ex_mem_rs2_data(rs2),
        .ex_mem_rd_addr(rd), .ex_mem_funct3(f3), .ex_mem_control_signals(ctrl),
        .ex_mem_valid(vld), .dmem(dmem),
        .mem_stall(mem_stall), .mem_fault(mem_fault), .mem_fault_cause(mem_fault_cause),
        .mem_wb_pc(mem_wb_pc), .mem_wb_alu_result(mem_wb_alu_result),
        .mem_wb_mem_data(mem_wb_mem_data), .mem_wb_rd_addr(mem_wb_rd_addr),
        .mem_wb_control_signals(mem_wb_control_signals), .mem_wb_valid(mem_wb_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    // Model of the last MEM/WB pc; only trusted while wb_known is set
    logic [31:0] wb_pc_m = 32'd0;
    bit          wb_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        return 1 << int'(f[1:0]);
    endfunction

    function automatic bit legal(input bit st, input logic [2:0] f, input logic [31:0] a);
        if (st && f > 3'd2) return 1'b0;
        if (!st && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (a % nbytes(f)) == 0;
    endfunction

    function automatic logic [31:0] m_be(input bit st, input logic [2:0] f, input logic [31:0] a);
        if (!st) return 32'hF;
        return (((32'd1 << nbytes(f)) - 1) << (a % 4)) & 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        if (nbytes(f) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (nbytes(f) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] w);
        int     n = nbytes(f);
        longint v;
        v = longint'(w >> (8 * (a % 4))) & ((longint'(1) << (8 * n)) - 1);
        if (f[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // Present one EX/MEM instruction (held while stalled) and check it to retirement.
    // lat = cycle index at which ready rises; lat > TO means never.
    task automatic run_op(input logic [31:0] pc_i, input logic [31:0] alu_i,
                          input logic [31:0] rs2_i, input logic [4:0] rd_i,
                          input logic [2:0] f3_i, input logic [CW-1:0] ctrl_i,
                          input logic vld_i, input int lat, input logic [31:0] rdata_i);
        bit st, acc, ok, rdy;
        pc = pc_i; alu = alu_i; rs2 = rs2_i; rd = rd_i; f3 = f3_i; ctrl = ctrl_i; vld = vld_i;
        st  = ctrl_i[1];
        acc = vld_i && (ctrl_i[0] || st);
        ok  = legal(st, f3_i, alu_i);
        if (!acc || !ok) begin
            dmem.ready = 1'($urandom_range(0, 1));
            dmem.rdata = $urandom();
            @(negedge clk);
            chk("req_noacc", 32'(dmem.req), 32'd0);
            chk("stall_noacc", 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            if (!acc) begin
                chk("wb_valid_pass", 32'(mem_wb_valid), 32'(vld_i));
                chk("wb_pc_pass", mem_wb_pc, pc_i);
                chk("wb_alu_pass", mem_wb_alu_result, alu_i);
                chk("wb_rd_pass", 32'(mem_wb_rd_addr), 32'(rd_i));
                chk("wb_ctrl_pass", 32'(mem_wb_control_signals), 32'(ctrl_i));
                chk("wb_data_pass", mem_wb_mem_data, 32'd0);
                chk("fault_pass", 32'(mem_fault), 32'd0);
                wb_pc_m = pc_i; wb_known = 1'b1;
            end else begin
                chk("fault_mis", 32'(mem_fault), 32'd1);
                chk("cause_mis", 32'(mem_fault_cause), 32'd0);
                chk("wb_valid_mis", 32'(mem_wb_valid), 32'd0);
                wb_known = 1'b0;
            end
            return;
        end
        for (int k = 0; k <= TO; k++) begin
            rdy = (k == lat);
            dmem.ready = rdy;
            dmem.rdata = rdy ? rdata_i : $urandom();
            @(negedge clk);
            chk("req", 32'(dmem.req), 32'd1);
            chk("we", 32'(dmem.we), 32'(st));
            chk("addr", dmem.addr, alu_i & ~32'd3);
            chk("be", 32'(dmem.be), m_be(st, f3_i, alu_i));
            if (st) chk("wdata", dmem.wdata, m_wdata(f3_i, rs2_i));
            chk("stall", 32'(mem_stall), 32'(!rdy));
            @(posedge clk); #1;
            if (rdy) begin
                chk("wb_valid_ret", 32'(mem_wb_valid), 32'd1);
                chk("wb_pc_ret", mem_wb_pc, pc_i);
                chk("wb_alu_ret", mem_wb_alu_result, alu_i);
                chk("wb_rd_ret", 32'(mem_wb_rd_addr), 32'(rd_i));
                chk("wb_ctrl_ret", 32'(mem_wb_control_signals), 32'(ctrl_i));
                chk("wb_data_ret", mem_wb_mem_data, st ? 32'd0 : m_load(f3_i, alu_i, rdata_i));
                chk("fault_ret", 32'(mem_fault), 32'd0);
                wb_pc_m = pc_i; wb_known = 1'b1;
                return;
            end
            chk("wb_valid_bub", 32'(mem_wb_valid), 32'd0);
            chk("wb_ctrl_bub", 32'(mem_wb_control_signals), 32'd0);
            if (wb_known) chk("wb_pc_hold", mem_wb_pc, wb_pc_m);
            chk("fault_wait", 32'(mem_fault), 32'(k == TO));
        end
        // Timed out: now in the one-cycle fault state
        chk("cause_to", 32'(mem_fault_cause), 32'd1);
        dmem.ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("req_fault", 32'(dmem.req), 32'd0);
        chk("stall_fault", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("fault_clear", 32'(mem_fault), 32'd0);
        chk("wb_valid_fault", 32'(mem_wb_valid), 32'd0);
        wb_known = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pc = 0; alu = 0; rs2 = 0; rd = 0; f3 = 0; ctrl = 0; vld = 0;
        dmem.ready = 1'b0; dmem.rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_pc", mem_wb_pc, 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_req", 32'(dmem.req), 32'd0);
        reset = 1'b1;
        wb_pc_m = 32'd0; wb_known = 1'b1;

        // ADD-type pass-through
        run_op(32'h100, 32'h1234, 32'h0, 5'd3, 3'd0, 8'h80, 1'b1, 0, 32'h0);
        // LB, zero-wait, top byte sign-extended
        run_op(32'h104, 32'h103, 32'h0, 5'd4, 3'd0, 8'h01, 1'b1, 0, 32'h80FF_FFFF);
        // SH upper half, ready after 3 wait cycles
        run_op(32'h108, 32'h102, 32'hAAAA_BEEF, 5'd0, 3'd1, 8'h02, 1'b1, 3, 32'h0);
        // LW misaligned
        run_op(32'h10C, 32'h101, 32'h0, 5'd5, 3'd2, 8'h01, 1'b1, 0, 32'h0);
        // LW that never completes
        run_op(32'h110, 32'h200, 32'h0, 5'd6, 3'd2, 8'h01, 1'b1, 99, 32'h0);
        // Read and write together: store wins
        run_op(32'h114, 32'h300, 32'h1122_3344, 5'd7, 3'd0, 8'h03, 1'b1, 1, 32'h0);

        for (int i = 0; i < 200; i++) begin
            run_op($urandom(), $urandom(), $urandom(), 5'($urandom()), 3'($urandom()),
                   CW'($urandom()), ($urandom_range(0, 7) != 0), $urandom_range(0, 6),
                   $urandom());
        end

        // Reset in the middle of an access
        pc = 32'h400; alu = 32'h300; rs2 = 0; rd = 5'd9; f3 = 3'd2; ctrl = 8'h01; vld = 1'b1;
        dmem.ready = 1'b0;
        @(negedge clk); chk("r6_req0", 32'(dmem.req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("r6_req1", 32'(dmem.req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("r6_req2", 32'(dmem.req), 32'd1);
        reset = 1'b0;
        #1;
        chk("r6_req_forced", 32'(dmem.req), 32'd0);
        @(posedge clk); #1;
        chk("r6_valid", 32'(mem_wb_valid), 32'd0);
        chk("r6_pc", mem_wb_pc, 32'd0);
        chk("r6_alu", mem_wb_alu_result, 32'd0);
        chk("r6_data", mem_wb_mem_data, 32'd0);
        chk("r6_ctrl", 32'(mem_wb_control_signals), 32'd0);
        chk("r6_fault", 32'(mem_fault), 32'd0);
        chk("r6_cause", 32'(mem_fault_cause), 32'd0);
        reset = 1'b1;
        wb_pc_m = 32'd0; wb_known = 1'b1;
        // LHU straight after reset: must behave as from idle
        run_op(32'h500, 32'h202, 32'h0, 5'd10, 3'd5, 8'h01, 1'b1, 0, 32'h8001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
